gpr_bank: RTL

//  Responder end of the GPR bus handshake (cs / read / address / data / ready).

---
 rtl/gpr_bank.sv | 110 +++++++++++
 1 files changed

// File: rtl/gpr_bank.sv
// GPR bus responder: DEPTH x DATA_W register file behind a shared tri-state data bus,
// serving one read or write per cs/ready handshake with optional wait states.

module gpr_cell #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

module gpr_bank #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data,
  output logic              ready,
  output logic              err
);
  localparam int         IDX_W  = $clog2(DEPTH);
  localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, DECODE, ACCESS, ACK} state_t;

  // Transfer attributes captured once in DECODE and held for the rest of the transfer.
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             rd;
    logic             oor;
  } xfer_t;

  state_t                        state, state_nx;
  xfer_t                         cur;
  logic [3:0]                    wcnt;
  logic [DEPTH-1:0][DATA_W-1:0]  regs;
  logic [DATA_W-1:0]             rdata;
  logic                          acc_done;
  logic                          commit;
  logic                          drive_en;

  assign acc_done = (state == ACCESS) && cs && (wcnt == WAIT_L);
  assign commit   = acc_done && !cur.rd && !cur.oor;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cs) state_nx = DECODE;
      DECODE:  state_nx = cs ? ACCESS : IDLE;
      ACCESS: begin
        if (!cs)          state_nx = IDLE;
        else if (acc_done) state_nx = ACK;
      end
      ACK:     state_nx = cs ? DECODE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur   <= '0;
      wcnt  <= '0;
      ready <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == DECODE) begin
        cur.idx <= address[IDX_W-1:0];
        cur.rd  <= read;
        cur.oor <= |address[ADDR_W-1:IDX_W];
        wcnt    <= '0;
      end else if (state == ACCESS && cs && !acc_done) begin
        wcnt <= wcnt + 4'd1;
      end
      // Registered from next-state so ready/err have no combinational input path.
      ready <= (state_nx == ACK);
      err   <= (state_nx == ACK) && cur.oor;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    gpr_cell #(.W(DATA_W)) u_cell (
      .clk (clk),
      .rst (rst),
      .we  (commit && (cur.idx == IDX_W'(g))),
      .d   (data),
      .q   (regs[g])
    );
  end

  // Out-of-range reads return zero rather than an aliased register.
  assign rdata    = cur.oor ? '0 : regs[cur.idx];
  assign drive_en = cur.rd && ((state == ACCESS) || (state == ACK));
  assign data     = drive_en ? rdata : 'z;

endmodule
